hwpe_stream_elastic_buffer: RTL and testbench

Parametrised multi-stage stream pipeline buffer on the hwpe_stream_intf_stream protocol. It cuts forward combinational paths (data/strb/valid) and, optionally, the backward ready path. It collapses bubbles so it sustains full throughput, and exposes occupancy. It is the drop-in successor for single-register stream buffers between streamers, engines and FIFOs.

---
 rtl/hwpe_stream_package.sv | 19 +
 rtl/hwpe_stream_intf_stream.sv | 26 ++
 rtl/hwpe_stream_elastic_stage.sv | 113 +++++++++++
 rtl/hwpe_stream_elastic_buffer.sv | 86 ++++++++
 tb/tb_hwpe_stream_elastic_buffer.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types for the hwpe stream elastic buffer.
// Stage state encoding and a capacity helper.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } hwpe_stream_buf_state_t;

    // Beats a chain of stages can hold.
    function automatic int unsigned buf_capacity(
        input int unsigned nb_stages,
        input bit          cut_ready
    );
        return nb_stages * (cut_ready ? 2 : 1);
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle carrying data and byte strobes.
// source drives the beat, sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

endinterface

// File: rtl/hwpe_stream_elastic_stage.sv
// One register stage of the elastic buffer.
// Spill register with registered ready, or single slot.
module hwpe_stream_elastic_stage
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          CUT_READY  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_strb
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    hwpe_stream_buf_state_t state_q, state_d;
    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    beat_t in_beat;
    logic  in_hs;
    logic  out_hs;

    assign in_beat   = '{strb: in_strb, data: in_data};
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q.data;
    assign out_strb  = main_q.strb;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    if (CUT_READY) begin : g_spill

        // Ready depends only on local state, never on out_ready.
        assign in_ready = (state_q != BUF_TWO);

        // Next state: main slot feeds the output, skid absorbs a stall.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                BUF_EMPTY: begin
                    if (in_hs) begin
                        state_d = BUF_ONE;
                        main_d  = in_beat;
                    end
                end
                BUF_ONE: begin
                    if (in_hs && out_hs) begin
                        main_d = in_beat;
                    end else if (in_hs) begin
                        state_d = BUF_TWO;
                        skid_d  = in_beat;
                    end else if (out_hs) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (out_hs) begin
                        state_d = BUF_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end

    end else begin : g_single

        // Passing ready through lets a full slot refill while it drains.
        assign in_ready = (state_q == BUF_EMPTY) | out_ready;

        // Next state: single slot, reload on every accepted beat.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = '0;
            if (in_hs) begin
                state_d = BUF_ONE;
                main_d  = in_beat;
            end else if (out_hs) begin
                state_d = BUF_EMPTY;
            end
        end

    end

    // State and slot registers; flush drops everything held.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/hwpe_stream_elastic_buffer.sv
// Chain of elastic stages between two streams.
// Tracks occupancy so upstream can see empty/full.
module hwpe_stream_elastic_buffer
    import hwpe_stream_package::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NB_STAGES  = 2,
    parameter bit          CUT_READY  = 1'b1,
    localparam int unsigned CAP       = buf_capacity(NB_STAGES, CUT_READY),
    localparam int unsigned CNT_WIDTH = $clog2(CAP + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  test_mode_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    if (NB_STAGES < 1) begin : g_bad_stages
        $error("hwpe_stream_elastic_buffer: NB_STAGES must be >= 1");
    end

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid [NB_STAGES+1];
    logic                  ready [NB_STAGES+1];
    logic [DATA_WIDTH-1:0] data  [NB_STAGES+1];
    logic [STRB_WIDTH-1:0] strb  [NB_STAGES+1];

    logic                 push_hs;
    logic                 pop_hs;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign valid[0]     = push_i.valid;
    assign data[0]      = push_i.data;
    assign strb[0]      = push_i.strb;
    assign push_i.ready = ready[0] & ~clear_i & ~rst_i;

    assign pop_o.valid      = valid[NB_STAGES];
    assign pop_o.data       = data[NB_STAGES];
    assign pop_o.strb       = strb[NB_STAGES];
    assign ready[NB_STAGES] = pop_o.ready;

    for (genvar i = 0; i < NB_STAGES; i++) begin : g_stage
        hwpe_stream_elastic_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .CUT_READY  (CUT_READY)
        ) i_stage (
            .clk       (clk_i),
            .rst       (rst_i),
            .clear     (clear_i),
            .in_valid  (valid[i]),
            .in_ready  (ready[i]),
            .in_data   (data[i]),
            .in_strb   (strb[i]),
            .out_valid (valid[i+1]),
            .out_ready (ready[i+1]),
            .out_data  (data[i+1]),
            .out_strb  (strb[i+1])
        );
    end

    assign push_hs = push_i.valid & push_i.ready;
    assign pop_hs  = pop_o.valid & pop_o.ready;

    // Occupancy follows accepted and delivered beats.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_WIDTH'(push_hs) - CNT_WIDTH'(pop_hs);
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_WIDTH'(CAP));

endmodule

// File: tb/tb_hwpe_stream_elastic_buffer.sv
// Directed and random checks of the elastic buffer.
// Four instances: (2,cut) (2,pass) (3,cut) (1,pass).
module tb_hwpe_stream_elastic_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        test_mode = 1'b0;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        out_ready;

    logic        p_ready [4];
    logic        o_valid [4];
    logic [31:0] o_data  [4];
    logic [3:0]  o_strb  [4];
    logic [3:0]  cnt     [4];
    logic        full    [4];
    logic        empty   [4];

    logic [2:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] cnt_c;
    logic [0:0] cnt_d;

    int nb  [4];
    int cap [4];
    int acc [4];
    int pops [4];
    logic [35:0] sb [4][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_b ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_b ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_c ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_c ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_d ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_d ();

    assign push_a.valid = in_valid;
    assign push_a.data  = in_data;
    assign push_a.strb  = in_strb;
    assign pop_a.ready  = out_ready;
    assign push_b.valid = in_valid;
    assign push_b.data  = in_data;
    assign push_b.strb  = in_strb;
    assign pop_b.ready  = out_ready;
    assign push_c.valid = in_valid;
    assign push_c.data  = in_data;
    assign push_c.strb  = in_strb;
    assign pop_c.ready  = out_ready;
    assign push_d.valid = in_valid;
    assign push_d.data  = in_data;
    assign push_d.strb  = in_strb;
    assign pop_d.ready  = out_ready;

    assign p_ready[0] = push_a.ready;
    assign o_valid[0] = pop_a.valid;
    assign o_data[0]  = pop_a.data;
    assign o_strb[0]  = pop_a.strb;
    assign cnt[0]     = {1'b0, cnt_a};
    assign p_ready[1] = push_b.ready;
    assign o_valid[1] = pop_b.valid;
    assign o_data[1]  = pop_b.data;
    assign o_strb[1]  = pop_b.strb;
    assign cnt[1]     = {2'b0, cnt_b};
    assign p_ready[2] = push_c.ready;
    assign o_valid[2] = pop_c.valid;
    assign o_data[2]  = pop_c.data;
    assign o_strb[2]  = pop_c.strb;
    assign cnt[2]     = {1'b0, cnt_c};
    assign p_ready[3] = push_d.ready;
    assign o_valid[3] = pop_d.valid;
    assign o_data[3]  = pop_d.data;
    assign o_strb[3]  = pop_d.strb;
    assign cnt[3]     = {3'b0, cnt_d};

    hwpe_stream_elastic_buffer #(
        .DATA_WIDTH(32), .NB_STAGES(2), .CUT_READY(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(test_mode),
        .push_i(push_a), .pop_o(pop_a), .count_o(cnt_a),
        .empty_o(empty[0]), .full_o(full[0])
    );

    hwpe_stream_elastic_buffer #(
        .DATA_WIDTH(32), .NB_STAGES(2), .CUT_READY(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(test_mode),
        .push_i(push_b), .pop_o(pop_b), .count_o(cnt_b),
        .empty_o(empty[1]), .full_o(full[1])
    );

    hwpe_stream_elastic_buffer #(
        .DATA_WIDTH(32), .NB_STAGES(3), .CUT_READY(1'b1)
    ) dut_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(test_mode),
        .push_i(push_c), .pop_o(pop_c), .count_o(cnt_c),
        .empty_o(empty[2]), .full_o(full[2])
    );

    hwpe_stream_elastic_buffer #(
        .DATA_WIDTH(32), .NB_STAGES(1), .CUT_READY(1'b0)
    ) dut_d (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .test_mode_i(test_mode),
        .push_i(push_d), .pop_o(pop_d), .count_o(cnt_d),
        .empty_o(empty[3]), .full_o(full[3])
    );

    // Advance one clock and update the per-instance reference queues.
    task automatic tick();
        logic phs [4];
        logic ohs [4];
        for (int k = 0; k < 4; k++) begin
            phs[k] = in_valid & p_ready[k] & ~rst & ~clr;
            ohs[k] = o_valid[k] & out_ready & ~rst & ~clr;
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (rst || clr) begin
                sb[k].delete();
            end else begin
                if (ohs[k]) begin
                    pops[k]++;
                    if (sb[k].size() > 0) void'(sb[k].pop_front());
                end
                if (phs[k]) begin
                    acc[k]++;
                    sb[k].push_back({in_strb, in_data});
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        in_strb = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                checks += 5;
                if (o_valid[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_valid dut%0d: got %b want 0", k, o_valid[k]);
                end
                if (o_data[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_data dut%0d: got %h want 0", k, o_data[k]);
                end
                if (cnt[k] !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_count dut%0d: got %0d want 0", k, cnt[k]);
                end
                if (empty[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_empty dut%0d: got %b want 1", k, empty[k]);
                end
                if (full[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_full dut%0d: got %b want 0", k, full[k]);
                end
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_streaming();
        int idx;
        logic ev;
        out_ready = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            in_valid = (j <= 16);
            in_data  = 32'(j);
            in_strb  = 4'(j * 3);
            #1;
            if (j <= 16) begin
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (p_ready[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL stream_ready dut%0d beat %0d: got %b want 1", k, j, p_ready[k]);
                    end
                end
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                idx = j - nb[k] + 1;
                ev = (idx >= 1) && (idx <= 16);
                checks++;
                if (o_valid[k] !== ev) begin
                    errors++;
                    $display("FAIL stream_valid dut%0d edge %0d: got %b want %b", k, j, o_valid[k], ev);
                end
                if (ev) begin
                    checks += 2;
                    if (o_data[k] !== 32'(idx)) begin
                        errors++;
                        $display("FAIL stream_data dut%0d edge %0d: got %h want %h", k, j, o_data[k], idx);
                    end
                    if (o_strb[k] !== 4'(idx * 3)) begin
                        errors++;
                        $display("FAIL stream_strb dut%0d edge %0d: got %h want %h", k, j, o_strb[k], 4'(idx * 3));
                    end
                end
            end
        end
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (o_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle_valid dut%0d: got %b want 0", k, o_valid[k]);
            end
            if (o_data[k] !== 32'd16) begin
                errors++;
                $display("FAIL stream_hold_data dut%0d: got %h want 10", k, o_data[k]);
            end
            if (empty[k] !== 1'b1) begin
                errors++;
                $display("FAIL stream_empty dut%0d: got %b want 1", k, empty[k]);
            end
        end
    endtask

    task automatic test_backpressure_fill();
        int n [4];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            acc[k] = 0;
            n[k] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            in_strb  = 4'hF;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks += 4;
            if (acc[k] !== cap[k]) begin
                errors++;
                $display("FAIL fill_accepted dut%0d: got %0d want %0d", k, acc[k], cap[k]);
            end
            if (int'(cnt[k]) !== cap[k]) begin
                errors++;
                $display("FAIL fill_count dut%0d: got %0d want %0d", k, cnt[k], cap[k]);
            end
            if (full[k] !== 1'b1) begin
                errors++;
                $display("FAIL fill_full dut%0d: got %b want 1", k, full[k]);
            end
            if (p_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL fill_ready dut%0d: got %b want 0", k, p_ready[k]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (o_valid[k]) begin
                    checks++;
                    if (o_data[k] !== 32'h100 + 32'(n[k])) begin
                        errors++;
                        $display("FAIL drain_data dut%0d: got %h want %h", k, o_data[k], 32'h100 + 32'(n[k]));
                    end
                    n[k]++;
                end
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (n[k] !== cap[k]) begin
                errors++;
                $display("FAIL drain_beats dut%0d: got %0d want %0d", k, n[k], cap[k]);
            end
            if (empty[k] !== 1'b1) begin
                errors++;
                $display("FAIL drain_empty dut%0d: got %b want 1", k, empty[k]);
            end
        end
    endtask

    task automatic test_random();
        logic        prev_v [4];
        logic [35:0] prev_d [4];
        logic        prev_r;
        for (int k = 0; k < 4; k++) begin
            prev_v[k] = 1'b0;
            prev_d[k] = '0;
            pops[k] = 0;
        end
        prev_r = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_strb   = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (int'(cnt[k]) !== sb[k].size()) begin
                    errors++;
                    $display("FAIL rand_count dut%0d cyc %0d: got %0d want %0d", k, c, cnt[k], sb[k].size());
                end
                if (o_valid[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL rand_spurious dut%0d cyc %0d: got valid want no beat", k, c);
                    end else if ({o_strb[k], o_data[k]} !== sb[k][0]) begin
                        errors++;
                        $display("FAIL rand_data dut%0d cyc %0d: got %h want %h", k, c, {o_strb[k], o_data[k]}, sb[k][0]);
                    end
                end
                if (prev_v[k] && !prev_r) begin
                    checks++;
                    if (!o_valid[k] || {o_strb[k], o_data[k]} !== prev_d[k]) begin
                        errors++;
                        $display("FAIL rand_stable dut%0d cyc %0d: got %b/%h want 1/%h", k, c, o_valid[k], {o_strb[k], o_data[k]}, prev_d[k]);
                    end
                end
                if ((k == 0 || k == 2) && int'(cnt[k]) == cap[k]) begin
                    checks++;
                    if (p_ready[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_full_ready dut%0d cyc %0d: got %b want 0", k, c, p_ready[k]);
                    end
                end
                prev_v[k] = o_valid[k];
                prev_d[k] = {o_strb[k], o_data[k]};
            end
            prev_r = out_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (pops[k] < 1000) begin
                errors++;
                $display("FAIL rand_beats dut%0d: got %0d want >=1000", k, pops[k]);
            end
            if (sb[k].size() != 0) begin
                errors++;
                $display("FAIL rand_leftover dut%0d: got %0d want 0", k, sb[k].size());
            end
            if (empty[k] !== 1'b1) begin
                errors++;
                $display("FAIL rand_empty dut%0d: got %b want 1", k, empty[k]);
            end
        end
    endtask

    task automatic test_clear();
        logic ev;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h31 + 32'(i);
            in_strb  = 4'h3;
            tick();
        end
        checks++;
        if (cnt[0] !== 4'd3) begin
            errors++;
            $display("FAIL clear_pre_count dut0: got %0d want 3", cnt[0]);
        end
        clr = 1'b1;
        in_data = 32'hAA;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (p_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL clear_ready dut%0d: got %b want 0", k, p_ready[k]);
            end
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks += 4;
            if (cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL clear_count dut%0d: got %0d want 0", k, cnt[k]);
            end
            if (o_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL clear_valid dut%0d: got %b want 0", k, o_valid[k]);
            end
            if (o_data[k] !== 32'h0) begin
                errors++;
                $display("FAIL clear_data dut%0d: got %h want 0", k, o_data[k]);
            end
            if (empty[k] !== 1'b1 || full[k] !== 1'b0) begin
                errors++;
                $display("FAIL clear_flags dut%0d: got %b%b want 10", k, empty[k], full[k]);
            end
        end
        clr = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h55;
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ev = (j == nb[k]);
                checks++;
                if (o_valid[k] !== ev) begin
                    errors++;
                    $display("FAIL post_clear_valid dut%0d edge %0d: got %b want %b", k, j, o_valid[k], ev);
                end
                if (o_valid[k]) begin
                    checks++;
                    if (o_data[k] !== 32'h55) begin
                        errors++;
                        $display("FAIL post_clear_data dut%0d edge %0d: got %h want 55", k, j, o_data[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_simul_full();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_strb = 4'h1;
        in_data = 32'h61;
        tick();
        in_data = 32'h62;
        tick();
        checks += 2;
        if (cnt[1] !== 4'd2) begin
            errors++;
            $display("FAIL simul_pre_count: got %0d want 2", cnt[1]);
        end
        if (full[1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre_full: got %b want 1", full[1]);
        end
        in_data = 32'h63;
        out_ready = 1'b1;
        #1;
        checks++;
        if (p_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_ready: got %b want 1", p_ready[1]);
        end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (cnt[1] !== 4'd2) begin
            errors++;
            $display("FAIL simul_count: got %0d want 2", cnt[1]);
        end
        if (o_data[1] !== 32'h62) begin
            errors++;
            $display("FAIL simul_order0: got %h want 62", o_data[1]);
        end
        tick();
        checks += 2;
        if (o_data[1] !== 32'h63 || o_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_order1: got %b/%h want 1/63", o_valid[1], o_data[1]);
        end
        if (cnt[1] !== 4'd1) begin
            errors++;
            $display("FAIL simul_count1: got %0d want 1", cnt[1]);
        end
        tick();
        checks++;
        if (empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty: got %b want 1", empty[1]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nb[0] = 2;  cap[0] = 4;
        nb[1] = 2;  cap[1] = 2;
        nb[2] = 3;  cap[2] = 6;
        nb[3] = 1;  cap[3] = 1;
        for (int k = 0; k < 4; k++) begin
            acc[k] = 0;
            pops[k] = 0;
        end
        test_reset();
        test_streaming();
        test_backpressure_fill();
        test_random();
        test_clear();
        test_simul_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
